// File: rtl/alu_secuenciador_operandos.sv
// -----------------------------------------------------------------------------
// alu_secuenciador_operandos
//
// Front-end sequencer for the lab ALU. Operand A, operand B and the opcode are
// taken one at a time from the board switches. Each one is qualified by a
// rising edge of the load button. The three values are then presented to the
// combinational ALU for a single execute cycle. The ALU result and zero flag
// are registered on the closing edge of that cycle so they can be displayed.
//
// Parameters
//   M  operand/result width in bits (M >= 1)
//   N  opcode width in bits
//
// Ports
//   clk             in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   dato_entrada    in   [M] switch value to be loaded
//   boton_cargar    in   load button (level, debounced/synchronized)
//   boton_cancelar  in   abort button (level, debounced/synchronized)
//   resultado_alu   in   [M] result returned by the ALU
//   cero_alu        in   zero flag returned by the ALU
//   expresionA      out  [M] operand A driven to the ALU
//   expresionB      out  [M] operand B driven to the ALU
//   operacion       out  [N] opcode driven to the ALU
//   valido          out  high exactly during the execute cycle
//   resultado_reg   out  [M] captured ALU result
//   cero_reg        out  captured ALU zero flag
//   estado          out  [3] current state code (for LEDs)
// -----------------------------------------------------------------------------
module alu_secuenciador_operandos #(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] dato_entrada,
    input  logic         boton_cargar,
    input  logic         boton_cancelar,
    input  logic [M-1:0] resultado_alu,
    input  logic         cero_alu,
    output logic [M-1:0] expresionA,
    output logic [M-1:0] expresionB,
    output logic [N-1:0] operacion,
    output logic         valido,
    output logic [M-1:0] resultado_reg,
    output logic         cero_reg,
    output logic [2:0]   estado
);

    typedef enum logic [2:0] {
        CARGA_A  = 3'd0,
        CARGA_B  = 3'd1,
        CARGA_OP = 3'd2,
        EJECUTA  = 3'd3,
        MUESTRA  = 3'd4
    } estado_t;

    estado_t estado_actual;
    estado_t estado_sig;

    logic prev_cargar;
    logic prev_cancelar;
    logic carga;
    logic cancela;

    logic carga_a;
    logic carga_b;
    logic carga_op;
    logic captura;

    // Opcode comes from the M-bit switch bank: drop high bits when M > N,
    // zero-extend when M < N. Padding to M+N bits covers both cases.
    function automatic logic [N-1:0] ajusta_opcode(input logic [M-1:0] valor);
        logic [M+N-1:0] extendido;
        extendido = {{N{1'b0}}, valor};
        return extendido[N-1:0];
    endfunction

    // One-cycle events on button rising edges. History resets to 1 so that a
    // button already held when reset is released does not count as a press.
    assign carga   = boton_cargar   & ~prev_cargar;
    assign cancela = boton_cancelar & ~prev_cancelar;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cargar   <= 1'b1;
            prev_cancelar <= 1'b1;
        end else begin
            prev_cargar   <= boton_cargar;
            prev_cancelar <= boton_cancelar;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_actual <= CARGA_A;
        end else begin
            estado_actual <= estado_sig;
        end
    end

    // Next state and register write enables. Cancel beats a simultaneous
    // load everywhere except EJECUTA, which always completes.
    always_comb begin
        estado_sig = estado_actual;
        carga_a    = 1'b0;
        carga_b    = 1'b0;
        carga_op   = 1'b0;
        captura    = 1'b0;
        case (estado_actual)
            CARGA_A: begin
                if (cancela) begin
                    estado_sig = CARGA_A;
                end else if (carga) begin
                    carga_a    = 1'b1;
                    estado_sig = CARGA_B;
                end
            end
            CARGA_B: begin
                if (cancela) begin
                    estado_sig = CARGA_A;
                end else if (carga) begin
                    carga_b    = 1'b1;
                    estado_sig = CARGA_OP;
                end
            end
            CARGA_OP: begin
                if (cancela) begin
                    estado_sig = CARGA_A;
                end else if (carga) begin
                    carga_op   = 1'b1;
                    estado_sig = EJECUTA;
                end
            end
            EJECUTA: begin
                captura    = 1'b1;
                estado_sig = MUESTRA;
            end
            MUESTRA: begin
                if (cancela || carga) begin
                    estado_sig = CARGA_A;
                end
            end
            default: begin
                estado_sig = CARGA_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expresionA    <= '0;
            expresionB    <= '0;
            operacion     <= '0;
            resultado_reg <= '0;
            cero_reg      <= 1'b0;
        end else begin
            if (carga_a) begin
                expresionA <= dato_entrada;
            end
            if (carga_b) begin
                expresionB <= dato_entrada;
            end
            if (carga_op) begin
                operacion <= ajusta_opcode(dato_entrada);
            end
            if (captura) begin
                resultado_reg <= resultado_alu;
                cero_reg      <= cero_alu;
            end
        end
    end

    assign valido = (estado_actual == EJECUTA);
    assign estado = estado_actual;

endmodule

// File: tb/tb_alu_secuenciador_operandos.sv
// -----------------------------------------------------------------------------
// tb_alu_secuenciador_operandos
//
// Directed and randomized stimulus for the ALU operand sequencer. A small ALU
// stand-in answers the DUT's operands. An event-level model predicts the
// sequencer's visible state and registers after every button press.
// -----------------------------------------------------------------------------
module tb_alu_secuenciador_operandos;

    localparam int M = 4;
    localparam int N = 4;
    localparam logic [N-1:0] OP_XOR = 4'd4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [M-1:0] dato_entrada = '0;
    logic         boton_cargar = 1'b0;
    logic         boton_cancelar = 1'b0;
    logic [M-1:0] resultado_alu;
    logic         cero_alu;
    logic [M-1:0] expresionA;
    logic [M-1:0] expresionB;
    logic [N-1:0] operacion;
    logic         valido;
    logic [M-1:0] resultado_reg;
    logic         cero_reg;
    logic [2:0]   estado;

    int checks = 0;
    int errors = 0;
    int valido_visto = 0;

    // Event-level model of the sequencer
    int           m_state;
    logic [M-1:0] m_a, m_b, m_res;
    logic [N-1:0] m_op;
    logic         m_cero;
    int           m_ejecuciones;

    alu_secuenciador_operandos #(.M(M), .N(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dato_entrada   (dato_entrada),
        .boton_cargar   (boton_cargar),
        .boton_cancelar (boton_cancelar),
        .resultado_alu  (resultado_alu),
        .cero_alu       (cero_alu),
        .expresionA     (expresionA),
        .expresionB     (expresionB),
        .operacion      (operacion),
        .valido         (valido),
        .resultado_reg  (resultado_reg),
        .cero_reg       (cero_reg),
        .estado         (estado)
    );

    always #5 clk = ~clk;

    function automatic logic [M-1:0] alu_ref(input logic [M-1:0] a, input logic [M-1:0] b,
                                            input logic [N-1:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    // Combinational ALU stand-in
    always_comb begin
        resultado_alu = alu_ref(expresionA, expresionB, operacion);
        cero_alu      = (resultado_alu == '0);
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && valido === 1'b1) valido_visto++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_cero = 1'b0;
    endtask

    // One press of the given buttons, as seen once the sequencer has settled
    task automatic model_event(input bit load, input bit cancel, input logic [M-1:0] val);
        if (cancel && m_state != 3) begin
            m_state = 0;
        end else if (load) begin
            case (m_state)
                0: begin m_a = val; m_state = 1; end
                1: begin m_b = val; m_state = 2; end
                2: begin
                    m_op   = N'(val);
                    m_res  = alu_ref(m_a, m_b, m_op);
                    m_cero = (m_res == '0);
                    m_ejecuciones++;
                    m_state = 4;
                end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".estado"}, 32'(estado), 32'(m_state));
        check({tag, ".A"}, 32'(expresionA), 32'(m_a));
        check({tag, ".B"}, 32'(expresionB), 32'(m_b));
        check({tag, ".op"}, 32'(operacion), 32'(m_op));
        check({tag, ".res"}, 32'(resultado_reg), 32'(m_res));
        check({tag, ".cero"}, 32'(cero_reg), 32'(m_cero));
        check({tag, ".valido"}, 32'(valido), 32'd0);
    endtask

    task automatic press(input bit load, input bit cancel, input logic [M-1:0] val, input string tag);
        dato_entrada   = val;
        boton_cargar   = load;
        boton_cancelar = cancel;
        tick();
        boton_cargar   = 1'b0;
        boton_cancelar = 1'b0;
        dato_entrada   = M'($urandom);
        tick();
        model_event(load, cancel, val);
        check_all(tag);
    endtask

    initial begin
        logic [M-1:0] v;
        m_ejecuciones = 0;
        model_reset();

        // Reset with arbitrary inputs
        dato_entrada   = M'($urandom);
        boton_cancelar = 1'b0;
        boton_cargar   = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        check_all("reset");

        // Release reset with load button held: no event
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) tick();
        check_all("held_release");
        boton_cargar = 1'b0;
        tick();

        // Full op: 0xA ^ 0x6 = 0xC
        press(1'b1, 1'b0, 4'hA, "load_a");
        press(1'b1, 1'b0, 4'h6, "load_b");
        dato_entrada = OP_XOR;
        boton_cargar = 1'b1;
        tick();
        check("exec.estado", 32'(estado), 32'd3);
        check("exec.valido", 32'(valido), 32'd1);
        boton_cargar = 1'b0;
        tick();
        model_event(1'b1, 1'b0, OP_XOR);
        check("xor.res", 32'(resultado_reg), 32'hC);
        check("xor.cero", 32'(cero_reg), 32'd0);
        check_all("xor_full");

        // Zero flag: 5 ^ 5
        press(1'b1, 1'b0, 4'h0, "back_to_a");
        press(1'b1, 1'b0, 4'h5, "zero_a");
        press(1'b1, 1'b0, 4'h5, "zero_b");
        press(1'b1, 1'b0, OP_XOR, "zero_op");
        check("zero.res", 32'(resultado_reg), 32'h0);
        check("zero.cero", 32'(cero_reg), 32'd1);

        // Held load button for 20 cycles: exactly one load
        press(1'b1, 1'b0, 4'h0, "back_to_a2");
        v = M'($urandom);
        dato_entrada = v;
        boton_cargar = 1'b1;
        repeat (20) begin
            tick();
            dato_entrada = M'($urandom);
        end
        boton_cargar = 1'b0;
        tick();
        model_event(1'b1, 1'b0, v);
        check_all("held20");

        // Cancel and load together in CARGA_B: cancel wins
        press(1'b1, 1'b1, M'($urandom), "cancel_prio");

        // Cancel during EJECUTA is ignored
        press(1'b1, 1'b0, 4'h3, "ej_a");
        press(1'b1, 1'b0, 4'h9, "ej_b");
        dato_entrada = 4'd0;
        boton_cargar = 1'b1;
        tick();
        check("ej_cancel.valido", 32'(valido), 32'd1);
        boton_cargar   = 1'b0;
        boton_cancelar = 1'b1;
        tick();
        boton_cancelar = 1'b0;
        tick();
        model_event(1'b1, 1'b0, 4'd0);
        check_all("ej_cancel");

        // Asynchronous reset while in CARGA_OP
        press(1'b1, 1'b0, 4'h0, "rst_back");
        press(1'b1, 1'b0, 4'h7, "rst_a");
        press(1'b1, 1'b0, 4'h2, "rst_b");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #2 rst_n = 1'b1;
        tick();
        press(1'b1, 1'b0, 4'hB, "post_a");
        press(1'b1, 1'b0, 4'h4, "post_b");
        press(1'b1, 1'b0, 4'd1, "post_op");

        // Randomized button presses
        for (int i = 0; i < 60; i++) begin
            bit c;
            c = ($urandom_range(0, 5) == 0);
            press(!c || $urandom_range(0, 1) == 1, c,
                  (m_state == 2) ? M'($urandom_range(0, 5)) : M'($urandom), "rand");
        end

        check("valido_pulses", 32'(valido_visto), 32'(m_ejecuciones));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
